extremum_tracker: RTL and testbench
===================================

EXTREMUM_TRACKER -- requirements
Module: extremum_tracker

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32: stream width; SHALL be CHANNEL_COUNT times a multiple of 2.
REQ-002 SHALL have parameter CHANNEL_COUNT, default 2: packed signed channels per beat; SAMPLE_WIDTH = AXIS_TDATA_WIDTH/CHANNEL_COUNT; channel k = tdata[(k+1)*SAMPLE_WIDTH-1 : k*SAMPLE_WIDTH].
REQ-003 SYS_aclk  input  1  sole clock; all logic on rising edge.
REQ-004 SYS_areset  input  1  reset, synchronous, active-high.
REQ-005 EF_enable  input  1  run windows while high.
REQ-006 EF_log_count  input  5  window length = 2^EF_log_count accepted beats.
REQ-007 EF_log_shift  input  3  threshold shrink factor, arithmetic shift toward centre.
REQ-008 EF_lower_threshold  output  AXIS_TDATA_WIDTH  packed per-channel lower thresholds, signed.
REQ-009 EF_upper_threshold  output  AXIS_TDATA_WIDTH  packed per-channel upper thresholds, signed.
REQ-010 EF_update  output  1  one-cycle pulse when thresholds change.
REQ-011 S_AXIS_tvalid  input  1;  S_AXIS_tdata  input  AXIS_TDATA_WIDTH;  S_AXIS_tready  output  1.

Function
REQ-012 SHALL implement states IDLE, MEASURE, UPDATE; IDLE->MEASURE when EF_enable=1; MEASURE->UPDATE on final window beat; UPDATE->MEASURE if EF_enable=1, else IDLE.
REQ-013 S_AXIS_tready SHALL be 1 only in MEASURE; a beat is accepted only when tvalid and tready are both 1.
REQ-014 On IDLE->MEASURE and UPDATE->MEASURE, SHALL latch EF_log_count and EF_log_shift; changes mid-window SHALL have no effect until the next window.
REQ-015 First accepted beat of a window SHALL load per-channel min and max with that sample; each later accepted beat SHALL update them by signed compare.
REQ-016 Beat counter SHALL count accepted beats only; stalls (tvalid=0) SHALL neither advance it nor alter min/max.
REQ-017 Final beat = accepted beat number 2^log_count, with its sample included; log_count=0 SHALL give a 1-beat window with min=max=sample.
REQ-018 In UPDATE, per channel: centre = (max+min)>>>1 computed in SAMPLE_WIDTH+1 bits; lower = centre + ((min-centre)>>>shift); upper = centre + ((max-centre)>>>shift); results truncated to SAMPLE_WIDTH without overflow.
REQ-019 Threshold registers and EF_update=1 SHALL appear on the cycle after UPDATE, i.e. 2 cycles after the final beat is accepted; EF_update SHALL be 0 at all other times.
REQ-020 EF_enable falling mid-window SHALL let the window complete and update, then enter IDLE.
REQ-021 log_count=31 SHALL be supported; beat counter SHALL be 32 bits, with no wrap within a window.

Reset
REQ-022 Reset SHALL force IDLE, clear counter and min/max, set S_AXIS_tready=0 and EF_update=0.
REQ-023 Reset SHALL set every channel of EF_lower_threshold to the most positive value (0x7FFF at 16 bits) and EF_upper_threshold to the most negative value (0x8000).
REQ-024 Reset asserted mid-window or in UPDATE SHALL discard the window; thresholds SHALL take reset values and SHALL NOT be updated.

Configuration
REQ-025 Macro EXTREMUM_TRACKER_SMOOTH_EN defined: each threshold SHALL update as old + ((new-old)>>>1), computed in SAMPLE_WIDTH+1 bits; the first update after reset SHALL load new directly.
REQ-026 Macro EXTREMUM_TRACKER_SMOOTH_EN undefined: thresholds SHALL be replaced by new values; no smoothing logic present.

Verification
REQ-027 Defaults, log_count=2, shift=0, ch0 beats 10,-20,30,5 -> lower ch0=-20, upper ch0=30, EF_update pulse 2 cycles after 4th beat.
REQ-028 log_count=2, shift=1, ch1 beats -100,100,0,0 -> centre 0, lower=-50, upper=50; ch0 independent.
REQ-029 log_count=2 with tvalid low between beats and 3 stall cycles -> identical result to REQ-027; tready=0 in UPDATE.
REQ-030 log_count=0, beat ch0=0x7FFF -> lower=upper=0x7FFF, no overflow; EF_update each accepted beat.
REQ-031 Reset asserted after 2 of 4 beats -> thresholds 0x7FFF/0x8000, no EF_update; a following full window updates normally.
REQ-032 SMOOTH_EN defined, windows giving upper 100 then 200 -> upper outputs 100 then 150.

Source files
------------

// File: rtl/extremum_tracker_if.sv
// extremum_tracker_if: AXI4-Stream sample bus feeding the extremum tracker.
// The producer uses the master modport and the tracker uses the slave modport.
`timescale 1ns/1ps
interface extremum_tracker_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic                        tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] tdata;
    logic                        tready;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/extremum_tracker.sv
// extremum_tracker: measures per-channel min/max over windows of 2^log_count
// accepted beats and derives lower/upper thresholds shrunk toward the centre.
// Optional feature: define EXTREMUM_TRACKER_SMOOTH_EN to low-pass each
// threshold update (old + (new-old)/2); the first update after reset loads directly.
`timescale 1ns/1ps
module extremum_tracker #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CHANNEL_COUNT    = 2
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_areset,
    input  logic                        EF_enable,
    input  logic [4:0]                  EF_log_count,
    input  logic [2:0]                  EF_log_shift,
    output logic [AXIS_TDATA_WIDTH-1:0] EF_lower_threshold,
    output logic [AXIS_TDATA_WIDTH-1:0] EF_upper_threshold,
    output logic                        EF_update,
    extremum_tracker_if.slave           S_AXIS
);
    localparam int SW = AXIS_TDATA_WIDTH / CHANNEL_COUNT;
    localparam logic [SW-1:0] SAMPLE_MAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic [SW-1:0] SAMPLE_MIN = {1'b1, {(SW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MEASURE, UPDATE} state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic                          w_start;
    logic                          w_ready;
    logic                          w_accept;
    logic                          w_first;
    logic                          w_last;
    logic [31:0]                   r_count;
    logic [4:0]                    r_log_count;
    logic [2:0]                    r_log_shift;
    logic [AXIS_TDATA_WIDTH-1:0]   r_min;
    logic [AXIS_TDATA_WIDTH-1:0]   r_max;
    logic [AXIS_TDATA_WIDTH-1:0]   r_lower;
    logic [AXIS_TDATA_WIDTH-1:0]   r_upper;
    logic [AXIS_TDATA_WIDTH-1:0]   w_lower_next;
    logic [AXIS_TDATA_WIDTH-1:0]   w_upper_next;
    logic                          r_update;
`ifdef EXTREMUM_TRACKER_SMOOTH_EN
    logic                          r_first;
`endif

    assign w_ready       = (r_state == MEASURE);
    assign w_accept      = w_ready && S_AXIS.tvalid;
    assign w_first       = (r_count == 32'd0);
    // Count holds beats already taken, so the final beat arrives when it equals 2^n - 1.
    assign w_last        = (r_count == ((32'd1 << r_log_count) - 32'd1));
    assign S_AXIS.tready = w_ready;

    assign EF_lower_threshold = r_lower;
    assign EF_upper_threshold = r_upper;
    assign EF_update          = r_update;

    // State register.
    always_ff @(posedge SYS_aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (SYS_areset) r_state <= IDLE;
        else            r_state <= w_state_next;
    end

    // Next-state logic; a window starts on every entry into MEASURE.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (EF_enable) begin
                    w_state_next = MEASURE;
                    w_start      = 1'b1;
                end
            end
            MEASURE: begin
                if (w_accept && w_last) w_state_next = UPDATE;
            end
            UPDATE: begin
                w_start      = EF_enable;
                w_state_next = EF_enable ? MEASURE : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Window configuration latch and accepted-beat counter.
    always_ff @(posedge SYS_aclk) begin
        if (SYS_areset) begin
            r_count     <= '0;
            r_log_count <= '0;
            r_log_shift <= '0;
        end else if (w_start) begin
            r_count     <= '0;
            r_log_count <= EF_log_count;
            r_log_shift <= EF_log_shift;
        end else if (w_accept) begin
            r_count <= r_count + 32'd1;
        end
    end

    // Per-channel running min/max; the first beat of a window seeds both.
    always_ff @(posedge SYS_aclk) begin
        if (SYS_areset) begin
            r_min <= '0;
            r_max <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < CHANNEL_COUNT; k++) begin
                if (w_first || ($signed(S_AXIS.tdata[k*SW +: SW]) < $signed(r_min[k*SW +: SW])))
                    r_min[k*SW +: SW] <= S_AXIS.tdata[k*SW +: SW];
                if (w_first || ($signed(S_AXIS.tdata[k*SW +: SW]) > $signed(r_max[k*SW +: SW])))
                    r_max[k*SW +: SW] <= S_AXIS.tdata[k*SW +: SW];
            end
        end
    end

    // Threshold arithmetic is done one bit wider so max+min and max-centre cannot overflow.
    for (genvar k = 0; k < CHANNEL_COUNT; k++) begin : g_ch
        logic signed [SW:0]   w_min_x;
        logic signed [SW:0]   w_max_x;
        logic signed [SW:0]   w_centre;
        logic signed [SW-1:0] w_lo_raw;
        logic signed [SW-1:0] w_hi_raw;

        assign w_min_x  = {r_min[k*SW+SW-1], r_min[k*SW +: SW]};
        assign w_max_x  = {r_max[k*SW+SW-1], r_max[k*SW +: SW]};
        assign w_centre = (w_max_x + w_min_x) >>> 1;
        assign w_lo_raw = SW'(w_centre + ((w_min_x - w_centre) >>> r_log_shift));
        assign w_hi_raw = SW'(w_centre + ((w_max_x - w_centre) >>> r_log_shift));

`ifdef EXTREMUM_TRACKER_SMOOTH_EN
        logic signed [SW:0] w_lo_old;
        logic signed [SW:0] w_hi_old;
        logic signed [SW:0] w_lo_raw_x;
        logic signed [SW:0] w_hi_raw_x;

        assign w_lo_old   = {r_lower[k*SW+SW-1], r_lower[k*SW +: SW]};
        assign w_hi_old   = {r_upper[k*SW+SW-1], r_upper[k*SW +: SW]};
        assign w_lo_raw_x = {w_lo_raw[SW-1], w_lo_raw};
        assign w_hi_raw_x = {w_hi_raw[SW-1], w_hi_raw};
        assign w_lower_next[k*SW +: SW] = r_first ? w_lo_raw
                                                  : SW'(w_lo_old + ((w_lo_raw_x - w_lo_old) >>> 1));
        assign w_upper_next[k*SW +: SW] = r_first ? w_hi_raw
                                                  : SW'(w_hi_old + ((w_hi_raw_x - w_hi_old) >>> 1));
`else
        assign w_lower_next[k*SW +: SW] = w_lo_raw;
        assign w_upper_next[k*SW +: SW] = w_hi_raw;
`endif
    end

    // Threshold registers and update pulse, loaded at the end of the UPDATE cycle.
    always_ff @(posedge SYS_aclk) begin
        if (SYS_areset) begin
            r_lower  <= {CHANNEL_COUNT{SAMPLE_MAX}};
            r_upper  <= {CHANNEL_COUNT{SAMPLE_MIN}};
            r_update <= 1'b0;
`ifdef EXTREMUM_TRACKER_SMOOTH_EN
            r_first  <= 1'b1;
`endif
        end else begin
            r_update <= (r_state == UPDATE);
            if (r_state == UPDATE) begin
                r_lower <= w_lower_next;
                r_upper <= w_upper_next;
`ifdef EXTREMUM_TRACKER_SMOOTH_EN
                r_first <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_extremum_tracker.sv
// tb_extremum_tracker: directed table vectors, multi-cycle corner sequences
// and randomized windows checked against a behavioural threshold model.
`timescale 1ns/1ps
module tb_extremum_tracker;
    localparam int W  = 32;
    localparam int CH = 2;
    localparam int SW = 16;
    localparam int NR = 25;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic [4:0]   lc_in = '0;
    logic [2:0]   sh_in = '0;
    logic [W-1:0] lo_out;
    logic [W-1:0] hi_out;
    logic         upd;

    extremum_tracker_if #(.AXIS_TDATA_WIDTH(W)) s_axis ();

    extremum_tracker #(.AXIS_TDATA_WIDTH(W), .CHANNEL_COUNT(CH)) dut (
        .SYS_aclk           (clk),
        .SYS_areset         (rst),
        .EF_enable          (en),
        .EF_log_count       (lc_in),
        .EF_log_shift       (sh_in),
        .EF_lower_threshold (lo_out),
        .EF_upper_threshold (hi_out),
        .EF_update          (upd),
        .S_AXIS             (s_axis)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        lc;
        logic [2:0]        sh;
        int                stall;
        logic [3:0][31:0]  beats;
        logic [31:0]       exp_lo;
        logic [31:0]       exp_hi;
    } vec_t;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] stim_q[$];
    logic [W-1:0] got_lo;
    logic [W-1:0] got_hi;
    bit           m_first;
    int           m_lo[CH];
    int           m_hi[CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: thresholds from the window's samples using plain integer arithmetic.
    task automatic model_window(input int sh, output logic [W-1:0] lo, output logic [W-1:0] hi);
        lo = '0;
        hi = '0;
        for (int k = 0; k < CH; k++) begin
            int mn, mx, c, l, u, v;
            logic signed [SW-1:0] s;
            mn = 1 << 20;
            mx = -(1 << 20);
            foreach (stim_q[i]) begin
                s = stim_q[i][k*SW +: SW];
                v = s;
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
            c = (mx + mn) >>> 1;
            l = c + ((mn - c) >>> sh);
            u = c + ((mx - c) >>> sh);
`ifdef EXTREMUM_TRACKER_SMOOTH_EN
            if (!m_first) begin
                l = m_lo[k] + ((l - m_lo[k]) >>> 1);
                u = m_hi[k] + ((u - m_hi[k]) >>> 1);
            end
`endif
            m_lo[k] = l;
            m_hi[k] = u;
            lo[k*SW +: SW] = l[SW-1:0];
            hi[k*SW +: SW] = u[SW-1:0];
        end
        m_first = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        s_axis.tvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tready", 32'(s_axis.tready), 32'd0);
        check("rst_update", 32'(upd), 32'd0);
        check("rst_lower", lo_out, 32'h7FFF_7FFF);
        check("rst_upper", hi_out, 32'h8000_8000);
        rst = 1'b0;
        m_first = 1'b1;
    endtask

    // Feeds stim_q as one window, then checks UPDATE timing and captures the thresholds.
    task automatic run_window(input int stall_pct, input bit scramble, input bit nxt_en,
                              input logic [4:0] nxt_lc, input logic [2:0] nxt_sh);
        int idx   = 0;
        int guard = 0;
        while (idx < stim_q.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
            check("no_early_update", 32'(upd), 32'd0);
            if (s_axis.tready && ($urandom_range(99) >= stall_pct)) begin
                s_axis.tvalid = 1'b1;
                s_axis.tdata  = stim_q[idx];
                idx++;
                if (scramble) begin
                    lc_in = 5'($urandom);
                    sh_in = 3'($urandom);
                    en    = 1'($urandom);
                end
            end else begin
                s_axis.tvalid = 1'b0;
                s_axis.tdata  = $urandom;
            end
        end
        if (idx < stim_q.size()) begin
            check("beat_timeout", 32'(idx), 32'(stim_q.size()));
            return;
        end
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        check("tready_in_update", 32'(s_axis.tready), 32'd0);
        check("update_too_early", 32'(upd), 32'd0);
        en    = nxt_en;
        lc_in = nxt_lc;
        sh_in = nxt_sh;
        @(negedge clk);
        check("update_pulse", 32'(upd), 32'd1);
        got_lo = lo_out;
        got_hi = hi_out;
        @(negedge clk);
        check("update_drop", 32'(upd), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] elo, ehi;
        logic [4:0]   lcs[NR+1];
        logic [2:0]   shs[NR+1];
        int           n, guard;
        bit           nxt;

        vecs[0] = '{5'd2, 3'd0, 0,  {32'h0000_0005, 32'h0000_001E, 32'h0000_FFEC, 32'h0000_000A},
                    32'h0000_FFEC, 32'h0000_001E};
        vecs[1] = '{5'd2, 3'd0, 60, {32'h0000_0005, 32'h0000_001E, 32'h0000_FFEC, 32'h0000_000A},
                    32'h0000_FFEC, 32'h0000_001E};
        vecs[2] = '{5'd2, 3'd1, 0,  {32'h0000_0005, 32'h0000_001E, 32'h0064_FFEC, 32'hFF9C_000A},
                    32'hFFCE_FFF8, 32'h0032_0011};
        vecs[3] = '{5'd0, 3'd0, 0,  {32'h0, 32'h0, 32'h0, 32'h8000_7FFF},
                    32'h8000_7FFF, 32'h8000_7FFF};
        vecs[4] = '{5'd1, 3'd3, 30, {32'h0, 32'h0, 32'h0002_8000, 32'h0001_7FFF},
                    32'h0001_EFFF, 32'h0001_0FFF};
        vecs[5] = '{5'd2, 3'd7, 0,  {32'hFFFE_0007, 32'hFFFF_0007, 32'hFFFF_0007, 32'hFFFF_0007},
                    32'hFFFE_0007, 32'hFFFE_0007};

        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        m_first       = 1'b1;

        // Table-driven vectors, each from a fresh reset.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            lc_in = vecs[v].lc;
            sh_in = vecs[v].sh;
            en    = 1'b1;
            stim_q.delete();
            for (int b = 0; b < (1 << vecs[v].lc); b++) stim_q.push_back(vecs[v].beats[b]);
            run_window(vecs[v].stall, 1'b0, 1'b0, vecs[v].lc, vecs[v].sh);
            check($sformatf("vec%0d_lower", v), got_lo, vecs[v].exp_lo);
            check($sformatf("vec%0d_upper", v), got_hi, vecs[v].exp_hi);
        end

        // Reset after 2 of 4 beats discards the window; the next window updates normally.
        do_reset();
        lc_in = 5'd2;
        sh_in = 3'd0;
        en    = 1'b1;
        n     = 0;
        guard = 0;
        while (n < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
            if (s_axis.tready) begin
                s_axis.tvalid = 1'b1;
                s_axis.tdata  = 32'h0007_FFFD;
                n++;
            end else begin
                s_axis.tvalid = 1'b0;
            end
        end
        check("midreset_beats", 32'(n), 32'd2);
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midreset_update", 32'(upd), 32'd0);
            check("midreset_lower", lo_out, 32'h7FFF_7FFF);
            check("midreset_upper", hi_out, 32'h8000_8000);
        end
        rst     = 1'b0;
        m_first = 1'b1;
        stim_q  = '{32'h0010_0020, 32'hFFF0_0030, 32'h0005_FF00, 32'h0000_0001};
        model_window(0, elo, ehi);
        run_window(20, 1'b0, 1'b0, 5'd2, 3'd0);
        check("after_midreset_lower", got_lo, elo);
        check("after_midreset_upper", got_hi, ehi);

        // Reset landing in the UPDATE cycle suppresses the update.
        do_reset();
        lc_in = 5'd0;
        en    = 1'b1;
        guard = 0;
        while (!s_axis.tready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("upd_reset_ready", 32'(s_axis.tready), 32'd1);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 32'h1234_0042;
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        check("upd_reset_in_update", 32'(s_axis.tready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("upd_reset_update", 32'(upd), 32'd0);
        check("upd_reset_lower", lo_out, 32'h7FFF_7FFF);
        check("upd_reset_upper", hi_out, 32'h8000_8000);
        rst = 1'b0;
        en  = 1'b0;

        // log_count=31: a long run of beats must not end the window.
        do_reset();
        lc_in = 5'd31;
        en    = 1'b1;
        n     = 0;
        guard = 0;
        while (n < 40 && guard < 200) begin
            @(negedge clk);
            guard++;
            check("lc31_no_update", 32'(upd), 32'd0);
            s_axis.tvalid = s_axis.tready;
            s_axis.tdata  = $urandom;
            if (s_axis.tready) n++;
        end
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        @(negedge clk);
        check("lc31_still_measuring", 32'(s_axis.tready), 32'd1);
        check("lc31_no_update_end", 32'(upd), 32'd0);

        // Two 1-beat windows with upper 100 then 200.
        do_reset();
        lc_in = 5'd0;
        sh_in = 3'd0;
        en    = 1'b1;
        stim_q = '{32'h0000_0064};
        run_window(0, 1'b0, 1'b1, 5'd0, 3'd0);
        check("smooth_first_upper", 32'(got_hi[15:0]), 32'd100);
        stim_q = '{32'h0000_00C8};
        run_window(0, 1'b0, 1'b0, 5'd0, 3'd0);
`ifdef EXTREMUM_TRACKER_SMOOTH_EN
        check("smooth_second_upper", 32'(got_hi[15:0]), 32'd150);
`else
        check("smooth_second_upper", 32'(got_hi[15:0]), 32'd200);
`endif

        // Randomized back-to-back windows with stalls, mid-window input changes and enable drops.
        do_reset();
        for (int i = 0; i <= NR; i++) begin
            lcs[i] = 5'($urandom_range(4));
            shs[i] = 3'($urandom_range(7));
        end
        lc_in = lcs[0];
        sh_in = shs[0];
        en    = 1'b1;
        for (int i = 0; i < NR; i++) begin
            stim_q.delete();
            for (int b = 0; b < (1 << lcs[i]); b++) begin
                logic [W-1:0] beat;
                for (int k = 0; k < CH; k++) begin
                    case ($urandom_range(3))
                        0:       beat[k*SW +: SW] = 16'h7FFF;
                        1:       beat[k*SW +: SW] = 16'h8000;
                        default: beat[k*SW +: SW] = 16'($urandom);
                    endcase
                end
                stim_q.push_back(beat);
            end
            model_window(int'(shs[i]), elo, ehi);
            nxt = 1'($urandom_range(1));
            run_window($urandom_range(50), 1'b1, nxt, lcs[i+1], shs[i+1]);
            check($sformatf("rand%0d_lower", i), got_lo, elo);
            check($sformatf("rand%0d_upper", i), got_hi, ehi);
            if (!nxt) en = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
